ip_packet_tx: RTL

- Transmit counterpart of ip_packet_rx.
- Takes a fixed-size result frame from the accelerator, plus a destination IP/MAC (normally the SRC_IP/SRC_MAC captured by ip_packet_rx).
- Serializes Ethernet header (14 B), IPv4 header (20 B) and payload as an 8-bit AXI-Stream toward the MAC TX FIFO.
- Computes the IPv4 header checksum in-block. Frames are byte-compatible with ip_packet_rx, so a loopback returns identical fields.

---
 rtl/ip_pkg.sv | 35 +++
 rtl/ip_checksum.sv | 35 +++
 rtl/ip_packet_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ip_pkg.sv
// ip_pkg: constants and types shared by the IPv4/Ethernet packet blocks.
//   - Header sizes, EtherType, version/IHL and flags bytes, which are common
//     to ip_packet_tx and ip_packet_rx.
//   - tx_state_t: state encoding of the ip_packet_tx sequencer.
//   - ones_add(): 16-bit one's-complement add with end-around carry.
`timescale 1ns/1ps
package ip_pkg;

  localparam int          ETH_HDR_SIZE_BYTES = 14;
  localparam int          IP_HDR_SIZE_BYTES  = 20;
  localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL         = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF        = 16'h4000;

  // The IPv4 header checksum covers the header as 16-bit words.
  localparam int          CSUM_WORDS         = IP_HDR_SIZE_BYTES / 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_CSUM,
    TX_SEND_ETH,
    TX_SEND_IP,
    TX_SEND_DATA
  } tx_state_t;

  // The carry out of a 16-bit add is folded straight back in, so the running
  // sum always stays in 16 bits; a second carry cannot occur (max 0x1FFFE).
  function automatic logic [15:0] ones_add(input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_checksum.sv
// ip_checksum: sequential one's-complement accumulator for the IPv4 header.
// Ports:
//   clk        clock
//   ARESET     asynchronous active-low reset
//   clear      restart the sum at zero (has priority over word_valid)
//   word_valid add 'word' into the running sum this cycle
//   word       16-bit header word
//   sum        folded running sum (not yet complemented)
`timescale 1ns/1ps
module ip_checksum
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        ARESET,
  input  logic        clear,
  input  logic        word_valid,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] sum_reg;

  always_ff @(posedge clk or negedge ARESET) begin
    if (!ARESET) begin
      sum_reg <= '0;
    end else if (clear) begin
      sum_reg <= '0;
    end else if (word_valid) begin
      sum_reg <= ones_add(sum_reg, word);
    end
  end

  assign sum = sum_reg;

endmodule

// File: rtl/ip_packet_tx.sv
// ip_packet_tx: builds an Ethernet + IPv4 frame around a fixed-size result
// payload and streams it out one byte per handshake (8-bit AXI-Stream).
// Ports:
//   ACLK, ARESET                       clock, asynchronous active-low reset
//   ACCELERATOR_IP/MAC_ADDRESS         source addresses
//   DST_IP/MAC_ADDRESS                 destination addresses
//   DATA_FRAME                         payload, byte i = DATA_FRAME[i*8+:8]
//   RESULT_VALID / RESULT_READY        request handshake (ready only in idle)
//   MAC_DATA_IN/VALID/READY/LAST/TUSER byte stream toward the MAC TX FIFO
//   BUSY                               packet in progress
// Addresses go on the wire least-significant byte first so that
// ip_packet_rx recovers the same port values on loopback.
`timescale 1ns/1ps
module ip_packet_tx
  import ip_pkg::*;
#(
  parameter int         USER_DATA_BYTES = 4,
  parameter logic [7:0] IP_PROTOCOL     = 8'h11,
  parameter logic [7:0] IP_TTL          = 8'h40
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
  input  logic [31:0]                  DST_IP_ADDRESS,
  input  logic [47:0]                  DST_MAC_ADDRESS,
  input  logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
  input  logic                         RESULT_VALID,
  output logic                         RESULT_READY,
  output logic [7:0]                   MAC_DATA_IN,
  output logic                         MAC_DATA_VALID,
  input  logic                         MAC_DATA_READY,
  output logic                         MAC_DATA_LAST,
  output logic                         MAC_DATA_TUSER,
  output logic                         BUSY
);

  localparam logic [15:0] IP_TOTAL_LEN = 16'(IP_HDR_SIZE_BYTES + USER_DATA_BYTES);
  localparam logic [15:0] LAST_WORD    = 16'(CSUM_WORDS - 1);
  localparam logic [15:0] LAST_ETH     = 16'(ETH_HDR_SIZE_BYTES - 1);
  localparam logic [15:0] LAST_IP      = 16'(IP_HDR_SIZE_BYTES - 1);
  localparam logic [15:0] LAST_DATA    = 16'(USER_DATA_BYTES - 1);

  tx_state_t   state_reg, state_next;
  logic [15:0] idx_reg, idx_next;     // checksum word index, then byte index
  logic [15:0] ident_reg, ident_next;
  logic        ready_reg;

  logic [31:0]                  src_ip_reg, dst_ip_reg;
  logic [47:0]                  src_mac_reg, dst_mac_reg;
  logic [USER_DATA_BYTES*8-1:0] frame_reg;

  logic        accept;
  logic        csum_clear, csum_valid;
  logic [15:0] csum_word, csum_sum, csum_field;

  logic [7:0]  eth_hdr [ETH_HDR_SIZE_BYTES];
  logic [7:0]  ip_hdr  [IP_HDR_SIZE_BYTES];

  assign accept = RESULT_VALID & ready_reg;

  // ---------------------------------------------------------------------
  // Request capture: the packet in flight only ever sees these copies.
  // ---------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      src_ip_reg  <= '0;
      dst_ip_reg  <= '0;
      src_mac_reg <= '0;
      dst_mac_reg <= '0;
      frame_reg   <= '0;
    end else if (accept) begin
      src_ip_reg  <= ACCELERATOR_IP_ADDRESS;
      dst_ip_reg  <= DST_IP_ADDRESS;
      src_mac_reg <= ACCELERATOR_MAC_ADDRESS;
      dst_mac_reg <= DST_MAC_ADDRESS;
      frame_reg   <= DATA_FRAME;
    end
  end

  // ---------------------------------------------------------------------
  // Header byte images, indexed by wire offset.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 6; gi++) begin : g_mac_bytes
    assign eth_hdr[gi]     = dst_mac_reg[gi*8 +: 8];
    assign eth_hdr[gi + 6] = src_mac_reg[gi*8 +: 8];
  end
  assign eth_hdr[12] = ETHERTYPE_IPV4[15:8];
  assign eth_hdr[13] = ETHERTYPE_IPV4[7:0];

  assign ip_hdr[0]  = IP_VER_IHL;
  assign ip_hdr[1]  = 8'h00;
  assign ip_hdr[2]  = IP_TOTAL_LEN[15:8];
  assign ip_hdr[3]  = IP_TOTAL_LEN[7:0];
  assign ip_hdr[4]  = ident_reg[15:8];
  assign ip_hdr[5]  = ident_reg[7:0];
  assign ip_hdr[6]  = IP_FLAGS_DF[15:8];
  assign ip_hdr[7]  = IP_FLAGS_DF[7:0];
  assign ip_hdr[8]  = IP_TTL;
  assign ip_hdr[9]  = IP_PROTOCOL;
  assign ip_hdr[10] = csum_field[15:8];
  assign ip_hdr[11] = csum_field[7:0];
  for (genvar gi = 0; gi < 4; gi++) begin : g_ip_bytes
    assign ip_hdr[12 + gi] = src_ip_reg[gi*8 +: 8];
    assign ip_hdr[16 + gi] = dst_ip_reg[gi*8 +: 8];
  end

  // ---------------------------------------------------------------------
  // Checksum: walk the same header image one word per CSUM cycle. Word 5
  // is the checksum field itself and is summed as zero. ident_reg only
  // changes on the final byte, so it is stable throughout the packet.
  // ---------------------------------------------------------------------
  assign csum_word = (idx_reg[3:0] == 4'd5) ? 16'h0000
                   : {ip_hdr[{idx_reg[3:0], 1'b0}], ip_hdr[{idx_reg[3:0], 1'b1}]};

  // A folded sum of all ones would complement to zero; zero is sent instead
  // of the equivalent negative-zero encoding.
  assign csum_field = (csum_sum == 16'hFFFF) ? 16'h0000 : ~csum_sum;

  ip_checksum u_checksum (
    .clk        (ACLK),
    .ARESET     (ARESET),
    .clear      (csum_clear),
    .word_valid (csum_valid),
    .word       (csum_word),
    .sum        (csum_sum)
  );

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_reg <= TX_IDLE;
      idx_reg   <= '0;
      ident_reg <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ident_reg <= ident_next;
      // Registered so that READY stays low throughout reset and rises on
      // the first clock after release.
      ready_reg <= (state_next == TX_IDLE);
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    ident_next     = ident_reg;
    csum_clear     = 1'b0;
    csum_valid     = 1'b0;
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_IN    = 8'h00;
    MAC_DATA_LAST  = 1'b0;

    unique case (state_reg)
      TX_IDLE: begin
        if (accept) begin
          state_next = TX_CSUM;
          idx_next   = '0;
          csum_clear = 1'b1;
        end
      end

      TX_CSUM: begin
        csum_valid = 1'b1;
        if (idx_reg == LAST_WORD) begin
          state_next = TX_SEND_ETH;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 16'd1;
        end
      end

      TX_SEND_ETH: begin
        MAC_DATA_VALID = 1'b1;
        MAC_DATA_IN    = eth_hdr[idx_reg[3:0]];
        if (MAC_DATA_READY) begin
          if (idx_reg == LAST_ETH) begin
            state_next = TX_SEND_IP;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 16'd1;
          end
        end
      end

      TX_SEND_IP: begin
        MAC_DATA_VALID = 1'b1;
        MAC_DATA_IN    = ip_hdr[idx_reg[4:0]];
        if (MAC_DATA_READY) begin
          if (idx_reg == LAST_IP) begin
            state_next = TX_SEND_DATA;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 16'd1;
          end
        end
      end

      TX_SEND_DATA: begin
        MAC_DATA_VALID = 1'b1;
        MAC_DATA_IN    = frame_reg[32'(idx_reg)*8 +: 8];
        MAC_DATA_LAST  = (idx_reg == LAST_DATA);
        if (MAC_DATA_READY) begin
          if (idx_reg == LAST_DATA) begin
            state_next = TX_IDLE;
            idx_next   = '0;
            ident_next = ident_reg + 16'd1;
          end else begin
            idx_next = idx_reg + 16'd1;
          end
        end
      end

      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

  assign RESULT_READY   = ready_reg;
  assign BUSY           = (state_reg != TX_IDLE);
  assign MAC_DATA_TUSER = 1'b0;

endmodule
